// File: rtl/sdram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter_pkg
//   Shared definitions for the SDRAM port arbiter slice:
//     - DATA_W          : command / read data width (16)
//     - arb_state_e     : arbiter FSM encoding (IDLE=0, ISSUE=1)
//     - addr_width()    : AW = ROW_BITS + COL_BITS + BANK_BITS
//     - port_id_width() : width of a port ID, clog2(NUM_PORTS), at least 1
// -----------------------------------------------------------------------------
package sdram_port_arbiter_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  function automatic int addr_width(input int row_bits, input int col_bits,
                                    input int bank_bits);
    return row_bits + col_bits + bank_bits;
  endfunction

  function automatic int port_id_width(input int num_ports);
    return (num_ports > 2) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// sdram_tag_fifo
//   Synchronous FIFO holding the port ID of every read accepted by the SDRAM
//   controller, so returning read data can be routed back in issue order.
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//     push, din  : write din when push=1 and not full (ignored when full)
//     pop        : drop the head entry when pop=1 and not empty (ignored
//                  when empty)
//     dout       : current head entry (valid while empty=0)
//     full/empty : occupancy flags
//     count      : number of stored entries, 0..DEPTH
//
//   Push and pop in the same cycle both take effect; the count is unchanged.
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sdram_tag_fifo #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_port_arbiter
//   Round-robin arbiter sharing one SDRAM controller command interface among
//   NUM_PORTS requesters. One winning request is latched onto cmd_* and held
//   until the controller accepts it; the port ID of every accepted read is
//   queued so returned read data is steered back to its requester in order.
//
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     req_valid      : per-port request valid
//     req_write      : per-port direction, 1=write 0=read
//     req_addr       : per-port address, port p at [p*AW +: AW]
//     req_wdata      : per-port write data, port p at [p*16 +: 16]
//     req_ready      : one-hot, 1-cycle accept pulse to the granted port
//     cmd_valid      : command to controller valid
//     cmd_write      : command direction
//     cmd_addr       : command address
//     cmd_wdata      : command write data
//     cmd_ready      : controller accept pulse
//     rd_valid       : controller read data valid
//     rd_data        : controller read data
//     rsp_valid      : one-hot read response valid
//     rsp_rdata      : read response data (shared, holds last value)
//     err_orphan     : sticky, read data arrived with no outstanding read
//     dbg_state      : arbiter FSM state
//     dbg_rr_ptr     : round-robin pointer (next port to be considered first)
//     dbg_tag_count  : outstanding reads held in the tag FIFO
//
//   Handshakes: a request transfers in the cycle where req_valid[p] and
//   req_ready[p] are both 1; the requester keeps req_* stable from raising
//   req_valid until that cycle (dropping req_valid earlier withdraws it).
//   A command transfers in the cycle where cmd_valid and cmd_ready are both
//   1; cmd_* stay constant while cmd_valid=1, and cmd_ready with
//   cmd_valid=0 has no effect.
// -----------------------------------------------------------------------------
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  parameter  int ROW_BITS  = 13,
  parameter  int COL_BITS  = 9,
  parameter  int BANK_BITS = 2,
  parameter  int MAX_RD    = 4,
  localparam int AW        = addr_width(ROW_BITS, COL_BITS, BANK_BITS),
  localparam int ID_W      = port_id_width(NUM_PORTS),
  localparam int CNT_W     = $clog2(MAX_RD) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*AW-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic                        cmd_valid,
  output logic                        cmd_write,
  output logic [AW-1:0]               cmd_addr,
  output logic [DATA_W-1:0]           cmd_wdata,
  input  logic                        cmd_ready,
  input  logic                        rd_valid,
  input  logic [DATA_W-1:0]           rd_data,
  output logic [NUM_PORTS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        err_orphan,
  output arb_state_e                  dbg_state,
  output logic [ID_W-1:0]             dbg_rr_ptr,
  output logic [CNT_W-1:0]            dbg_tag_count
);

  arb_state_e           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      cmd_port;

  logic [AW-1:0]        addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;
  logic                 grant_found;
  logic [ID_W-1:0]      grant_id;
  logic [NUM_PORTS-1:0] grant_oh;
  logic [ID_W-1:0]      rr_next;
  int                   cand;

  logic                 tag_push;
  logic                 tag_pop;
  logic [ID_W-1:0]      tag_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // Unpack the flat per-port buses into arrays indexed by port.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      addr_arr[p]  = req_addr[p*AW +: AW];
      wdata_arr[p] = req_wdata[p*DATA_W +: DATA_W];
    end
  end

  // A read is only eligible while the tag FIFO has room, so a read can never
  // be accepted by the controller without a slot for its tag.
  always_comb begin
    eligible    = req_valid & (req_write | {NUM_PORTS{~fifo_full}});
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) begin
        cand = cand - NUM_PORTS;
      end
      if (!grant_found && eligible[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(cand);
      end
    end
    grant_oh = grant_found ? (NUM_PORTS'(1) << grant_id) : '0;
    rr_next  = (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + ID_W'(1);
  end

  // The accept pulse is issued in the grant cycle itself, so the requester
  // can retire its request at the same edge that latches it into cmd_*.
  assign req_ready = (rst_n && state == ST_IDLE) ? grant_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      cmd_valid <= 1'b0;
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_port  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            cmd_valid <= 1'b1;
            cmd_write <= req_write[grant_id];
            cmd_addr  <= addr_arr[grant_id];
            cmd_wdata <= wdata_arr[grant_id];
            cmd_port  <= grant_id;
            rr_ptr    <= rr_next;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          cmd_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign tag_push = (state == ST_ISSUE) && cmd_ready && !cmd_write;
  assign tag_pop  = rd_valid && !fifo_empty;

  sdram_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_RD)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .din   (cmd_port),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read data is steered to the oldest outstanding read's port one cycle
  // after it arrives; data with nothing outstanding only raises the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= tag_pop ? (NUM_PORTS'(1) << tag_head) : '0;
      if (tag_pop) begin
        rsp_rdata <= rd_data;
      end
      if (rd_valid && fifo_empty) begin
        err_orphan <= 1'b1;
      end
    end
  end

  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;
  assign dbg_tag_count = fifo_count;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_port_arbiter
//   Self-checking bench for sdram_port_arbiter (2 ports, MAX_RD=4). A
//   transaction-level reference model (pending command, round-robin pointer,
//   queue of outstanding read tags) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_sdram_port_arbiter;
  import sdram_port_arbiter_pkg::*;

  localparam int NP     = 2;
  localparam int MAX_RD = 4;
  localparam int AW     = 24;
  localparam int ID_W   = 1;
  localparam int CNT_W  = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid;
  logic [NP-1:0]    req_write;
  logic [NP*AW-1:0] req_addr;
  logic [NP*16-1:0] req_wdata;
  logic [NP-1:0]    req_ready;
  logic             cmd_valid;
  logic             cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [15:0]      cmd_wdata;
  logic             cmd_ready;
  logic             rd_valid;
  logic [15:0]      rd_data;
  logic [NP-1:0]    rsp_valid;
  logic [15:0]      rsp_rdata;
  logic             err_orphan;
  arb_state_e       dbg_state;
  logic [ID_W-1:0]  dbg_rr_ptr;
  logic [CNT_W-1:0] dbg_tag_count;

  sdram_port_arbiter #(
    .NUM_PORTS (NP),
    .ROW_BITS  (13),
    .COL_BITS  (9),
    .BANK_BITS (2),
    .MAX_RD    (MAX_RD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .cmd_valid     (cmd_valid),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_ready     (cmd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .err_orphan    (err_orphan),
    .dbg_state     (dbg_state),
    .dbg_rr_ptr    (dbg_rr_ptr),
    .dbg_tag_count (dbg_tag_count)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit              m_busy;
  int              m_port;
  bit              m_write;
  logic [AW-1:0]   m_addr;
  logic [15:0]     m_wdata;
  int              m_rr;
  int              m_age;
  logic [ID_W-1:0] exp_q[$];
  logic [NP-1:0]   m_rsp_valid;
  logic [15:0]     m_rsp_data;
  bit              m_orphan;
  int              last_grant;

  // Observed DUT behaviour, for sequence-level checks
  int              dut_grants[$];
  logic [NP-1:0]   dut_rsps[$];

  // cmd_ready policy: 0 manual, 1 after ready_delay cycles of cmd_valid, 2 random
  int ready_mode  = 0;
  int ready_delay = 0;

  function automatic int model_pick();
    for (int i = 0; i < NP; i++) begin
      int p;
      p = (m_rr + i) % NP;
      if (req_valid[p] && (req_write[p] || exp_q.size() < MAX_RD)) return p;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------- driver
  // Entered and left at posedge+1; samples and checks on the falling edge.
  task automatic cycle();
    int              g;
    logic [NP-1:0]   exp_ready;
    logic [ID_W-1:0] h;
    if (ready_mode == 1) cmd_ready = m_busy && (m_age == ready_delay);
    else if (ready_mode == 2) cmd_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    g = m_busy ? -1 : model_pick();
    exp_ready = (g < 0) ? '0 : (NP'(1) << g);
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("cmd_valid", 32'(cmd_valid), 32'(m_busy));
    if (m_busy) begin
      check_eq("cmd_write", 32'(cmd_write), 32'(m_write));
      check_eq("cmd_addr", 32'(cmd_addr), 32'(m_addr));
      check_eq("cmd_wdata", 32'(cmd_wdata), 32'(m_wdata));
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp_data));
    check_eq("err_orphan", 32'(err_orphan), 32'(m_orphan));
    check_eq("dbg_state", 32'(dbg_state), m_busy ? 32'(ST_ISSUE) : 32'(ST_IDLE));
    check_eq("dbg_rr_ptr", 32'(dbg_rr_ptr), 32'(m_rr));
    check_eq("dbg_tag_count", 32'(dbg_tag_count), 32'(exp_q.size()));
    for (int p = 0; p < NP; p++) if (req_ready[p]) dut_grants.push_back(p);
    if (rsp_valid != '0) dut_rsps.push_back(rsp_valid);

    // Responses consume the oldest tag before this cycle's accept is queued.
    m_rsp_valid = '0;
    if (rd_valid) begin
      if (exp_q.size() > 0) begin
        h           = exp_q.pop_front();
        m_rsp_valid = NP'(1) << h;
        m_rsp_data  = rd_data;
      end else begin
        m_orphan = 1'b1;
      end
    end
    last_grant = g;
    if (g >= 0) begin
      m_busy  = 1'b1;
      m_port  = g;
      m_write = req_write[g];
      m_addr  = req_addr[g*AW +: AW];
      m_wdata = req_wdata[g*16 +: 16];
      m_rr    = (g + 1) % NP;
      m_age   = 0;
    end else if (m_busy) begin
      if (cmd_ready) begin
        if (!m_write) exp_q.push_back(ID_W'(m_port));
        m_busy = 1'b0;
      end else begin
        m_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    cmd_ready = 1'b0;
    rd_valid  = 1'b0;
    rst_n     = 1'b0;
    m_busy      = 1'b0;
    m_rr        = 0;
    m_age       = 0;
    m_rsp_valid = '0;
    m_rsp_data  = '0;
    m_orphan    = 1'b0;
    last_grant  = -1;
    exp_q.delete();
    #2;
    check_eq("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_err_orphan", 32'(err_orphan), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_eq("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    check_eq("rst_tag_count", 32'(dbg_tag_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic new_req(input int p, input bit wr);
    req_write[p]            = wr;
    req_addr[p*AW +: AW]    = AW'($urandom);
    req_wdata[p*16 +: 16]   = 16'($urandom);
    req_valid[p]            = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int n;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    cmd_ready = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    #1;
    do_reset();

    // Single write from port 0, accepted after cmd_valid has been up 2 cycles.
    ready_mode = 1; ready_delay = 2;
    req_write[0]       = 1'b1;
    req_addr[0 +: AW]  = 24'h000123;
    req_wdata[0 +: 16] = 16'hBEEF;
    req_valid          = 2'b01;
    cycle();
    req_valid = '0;
    check_eq("t1_cmd_addr", 32'(cmd_addr), 32'h000123);
    check_eq("t1_cmd_wdata", 32'(cmd_wdata), 32'hBEEF);
    repeat (4) cycle();
    check_eq("t1_no_push", 32'(dbg_tag_count), 32'd0);

    // Two ports requesting continuously: grants alternate.
    do_reset();
    dut_grants.delete();
    ready_mode = 1; ready_delay = 2;
    new_req(0, 1'b1);
    new_req(1, 1'b1);
    repeat (24) cycle();
    check_eq("t2_grant_count", 32'(dut_grants.size()), 32'd6);
    check_eq("t2_first_grant", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd0);
    for (int i = 1; i < dut_grants.size(); i++)
      check_eq("t2_alternate", 32'(dut_grants[i]), 32'(1 - dut_grants[i-1]));

    // Port 1 read, then read data returns to port 1.
    do_reset();
    ready_mode = 1; ready_delay = 0;
    new_req(1, 1'b0);
    cycle();
    req_valid = '0;
    repeat (2) cycle();
    check_eq("t3_tag_count", 32'(dbg_tag_count), 32'd1);
    rd_valid = 1'b1; rd_data = 16'h5A5A;
    cycle();
    rd_valid = 1'b0;
    check_eq("t3_rsp_valid", 32'(rsp_valid), 32'b10);
    check_eq("t3_rsp_rdata", 32'(rsp_rdata), 32'h5A5A);
    check_eq("t3_fifo_empty", 32'(dbg_tag_count), 32'd0);
    repeat (2) cycle();

    // Fill the tag FIFO with 4 reads; further reads stall, writes still go.
    do_reset();
    ready_mode = 1; ready_delay = 0;
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    n = 0;
    while (exp_q.size() < MAX_RD && n < 40) begin
      if (last_grant >= 0) new_req(last_grant, 1'b0);
      cycle();
      n++;
    end
    check_eq("t4_fill_timeout", 32'(n < 40), 32'd1);
    check_eq("t4_full_count", 32'(dbg_tag_count), 32'd4);
    req_valid[1] = 1'b0;
    cycle();
    dut_grants.delete();
    new_req(1, 1'b1);
    cycle();
    req_valid[1] = 1'b0;
    repeat (5) cycle();
    check_eq("t4_write_grants", 32'(dut_grants.size()), 32'd1);
    check_eq("t4_write_port", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd1);
    check_eq("t4_still_full", 32'(dbg_tag_count), 32'd4);
    req_valid = '0;
    dut_rsps.delete();
    for (int i = 0; i < 4; i++) begin
      rd_valid = 1'b1;
      rd_data  = 16'($urandom);
      cycle();
    end
    rd_valid = 1'b0;
    repeat (2) cycle();
    check_eq("t4_rsp_count", 32'(dut_rsps.size()), 32'd4);
    for (int i = 0; i < dut_rsps.size() && i < 4; i++)
      check_eq("t4_rsp_order", 32'(dut_rsps[i]), (i % 2 == 0) ? 32'b01 : 32'b10);

    // Randomised traffic checked cycle by cycle against the model.
    do_reset();
    ready_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (req_valid[p] && last_grant != p) begin
          if ($urandom_range(0, 9) == 0) req_valid[p] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          new_req(p, 1'($urandom_range(0, 1)));
        end else begin
          req_valid[p] = 1'b0;
        end
      end
      rd_valid = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
      rd_data  = 16'($urandom);
      cycle();
    end
    req_valid = '0;
    rd_valid  = 1'b0;
    repeat (4) cycle();

    // Read data with nothing outstanding: sticky error, no response.
    do_reset();
    ready_mode = 0;
    dut_rsps.delete();
    rd_valid = 1'b1; rd_data = 16'h1234;
    cycle();
    rd_valid = 1'b0;
    repeat (3) cycle();
    check_eq("t5_orphan", 32'(err_orphan), 32'd1);
    check_eq("t5_no_rsp", 32'(dut_rsps.size()), 32'd0);

    // Reset while a command is pending and two tags are outstanding.
    do_reset();
    ready_mode = 1; ready_delay = 0;
    new_req(0, 1'b0);
    new_req(1, 1'b0);
    n = 0;
    while (exp_q.size() < 2 && n < 20) begin
      if (last_grant >= 0) new_req(last_grant, 1'b0);
      cycle();
      n++;
    end
    ready_mode = 0;
    cmd_ready  = 1'b0;
    if (last_grant >= 0) new_req(last_grant, 1'b0);
    repeat (2) cycle();
    check_eq("t6_in_issue", 32'(dbg_state), 32'(ST_ISSUE));
    check_eq("t6_tags", 32'(dbg_tag_count), 32'd2);
    do_reset();
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
